irig_frame_sync: RTL and testbench
==================================

// Module: irig_frame_sync
// PURPOSE
//  Parametrised IRIG frame synchroniser, successor to the fixed IRIG-B field state machine.
//  Consumes classified symbol strobes (d0/d1/mark) from the pulse-width classifier and locates
//  the double-marker frame reference. Checks marker spacing every field and drops/regains lock
//  on framing errors. Emits indexed data-bit strobes for downstream BCD/SBS field assemblers,
//  plus frame/PPS pulses and error statistics.
// PARAMETERS
//  FIELDS      10  fields per frame; each field = BITS data symbols followed by one mark
//  BITS        9   data symbols per field (1..15)
//  LOCK_FRAMES 2   consecutive clean frames required before locked asserts (>=1)
//  ERR_W       16  width of saturating error counter
//  (FW = $clog2(FIELDS), BW = $clog2(BITS+1), both derived localparams, min 1)
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      asynchronous active-low reset
//  irig_d0     in   1      1-cycle strobe: data symbol '0' decoded
//  irig_d1     in   1      1-cycle strobe: data symbol '1' decoded
//  irig_mark   in   1      1-cycle strobe: position marker decoded
//  locked      out  1      frame lock established (level)
//  frame_start out  1      1-cycle pulse: frame reference marker (Pr) accepted
//  pps_gate    out  1      1-cycle pulse: frame_start while locked (after lock update)
//  bit_strobe  out  1      1-cycle pulse: data bit valid on field_idx/bit_idx/bit_value; locked only
//  field_idx   out  FW     field number of current bit, 0 = field after Pr
//  bit_idx     out  BW     bit position within field, 0..BITS-1
//  bit_value   out  1      1 for d1, 0 for d0
//  sym_err     out  1      1-cycle pulse: framing error detected
//  err_count   out  ERR_W  saturating framing error count (sticks at all-ones)
// BEHAVIOUR
//  - All outputs registered; each response appears the cycle after the input strobe.
//  - rst_n low (any time, incl. mid-frame): state UNLOCKED, all counters and outputs 0.
//  - Symbol = exactly one of d0/d1/mark high. >1 high = illegal symbol. None high = idle, no action.
//  - States: UNLOCKED, PRELOCK, FRAME, ENDMARK. Counters field_cnt[FW], bit_cnt[BW], good_cnt.
//  - UNLOCKED: mark -> PRELOCK; data/illegal ignored, no error counted.
//  - PRELOCK: mark -> FRAME, field_cnt=bit_cnt=0, frame_start=1; data -> UNLOCKED (no error);
//    illegal -> UNLOCKED (no error).
//  - FRAME data, bit_cnt<BITS: bit_cnt++, bit_strobe=locked, outputs field_cnt/bit_cnt/d1.
//  - FRAME data, bit_cnt==BITS (missing marker): error.
//  - FRAME mark, bit_cnt==BITS: field_cnt==FIELDS-1 -> ENDMARK; else field_cnt++, bit_cnt=0.
//  - FRAME mark, bit_cnt<BITS (early marker): error.
//  - ENDMARK mark (Pr): frame complete; good_cnt=min(good_cnt+1,LOCK_FRAMES);
//    -> FRAME, counters 0, frame_start=1; pps_gate=1 iff updated good_cnt==LOCK_FRAMES.
//  - ENDMARK data: error.
//  - Illegal symbol in FRAME/ENDMARK: error.
//  - Error: sym_err=1, err_count++ (saturating), good_cnt=0, locked deasserts next cycle;
//    next state PRELOCK if error symbol was a mark, else UNLOCKED.
//  - locked = (good_cnt==LOCK_FRAMES); rises with the pps_gate pulse of the qualifying frame.
//  - Errors only counted in FRAME/ENDMARK; err_count never wraps.
// TESTING
//  1 Reset, then mark,mark + 10x(9 data,mark) + mark: frame_start at 2nd and final mark; locked=0
//    after first frame (LOCK_FRAMES=2).
//  2 Two clean frames: locked and pps_gate rise together on 2nd Pr; third frame emits 90
//    bit_strobes with field_idx 0..9, bit_idx 0..8, bit_value matching d1 pattern.
//  3 Locked, mark after 5 bits in field 3: sym_err=1, err_count=1, locked=0, state PRELOCK;
//    next mark restarts frame (frame_start=1).
//  4 Locked, 10th data symbol in a field: sym_err, state UNLOCKED; d0 then mark,mark resyncs.
//  5 d0 and mark high same cycle in FRAME -> sym_err; same in UNLOCKED -> no error.
//  6 ERR_W=2: force 5 errors -> err_count=3; assert rst_n low mid-frame -> all outputs 0
//    asynchronously, bench re-locks after 2 frames.

Source files
------------

// File: rtl/irig_frame_sync.sv
// IRIG frame synchroniser: locks to the double-marker frame reference, checks marker spacing
// every field and emits indexed data-bit strobes, frame/PPS pulses and framing-error statistics.
module irig_frame_sync #(
    parameter int FIELDS      = 10,
    parameter int BITS        = 9,
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_W       = 16,
    localparam int FW = (FIELDS > 1) ? $clog2(FIELDS) : 1,
    localparam int BW = (BITS > 0) ? $clog2(BITS + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irig_d0,
    input  logic             irig_d1,
    input  logic             irig_mark,
    output logic             locked,
    output logic             frame_start,
    output logic             pps_gate,
    output logic             bit_strobe,
    output logic [FW-1:0]    field_idx,
    output logic [BW-1:0]    bit_idx,
    output logic             bit_value,
    output logic             sym_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [BW-1:0] BITS_C     = BW'(BITS);
    localparam logic [FW-1:0] FIELD_LAST = FW'(FIELDS - 1);
    localparam logic [GW-1:0] GOOD_MAX   = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {UNLOCKED, PRELOCK, FRAME, ENDMARK} state_e;

    state_e           state_q, state_d;
    logic [FW-1:0]    field_cnt_q, field_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             locked_q, locked_d;
    logic             frame_start_q, frame_start_d;
    logic             pps_gate_q, pps_gate_d;
    logic             bit_strobe_q, bit_strobe_d;
    logic [FW-1:0]    field_idx_q, field_idx_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic             bit_value_q, bit_value_d;
    logic             sym_err_q, sym_err_d;

    logic is_idle, is_mark, is_data, is_illegal;
    logic err_det, frame_ref, data_ok;

    // A symbol is legal only when exactly one strobe is high.
    assign is_idle    = !(irig_d0 || irig_d1 || irig_mark);
    assign is_mark    = irig_mark && !irig_d0 && !irig_d1;
    assign is_data    = (irig_d0 ^ irig_d1) && !irig_mark;
    assign is_illegal = !is_idle && !is_mark && !is_data;
    assign data_ok    = (state_q == FRAME) && is_data && (bit_cnt_q < BITS_C);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= UNLOCKED;
            field_cnt_q   <= '0;
            bit_cnt_q     <= '0;
            good_cnt_q    <= '0;
            err_count_q   <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            pps_gate_q    <= 1'b0;
            bit_strobe_q  <= 1'b0;
            field_idx_q   <= '0;
            bit_idx_q     <= '0;
            bit_value_q   <= 1'b0;
            sym_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            field_cnt_q   <= field_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            good_cnt_q    <= good_cnt_d;
            err_count_q   <= err_count_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            pps_gate_q    <= pps_gate_d;
            bit_strobe_q  <= bit_strobe_d;
            field_idx_q   <= field_idx_d;
            bit_idx_q     <= bit_idx_d;
            bit_value_q   <= bit_value_d;
            sym_err_q     <= sym_err_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        field_cnt_d = field_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_det     = 1'b0;
        frame_ref   = 1'b0;
        unique case (state_q)
            UNLOCKED: if (is_mark) state_d = PRELOCK;
            PRELOCK: begin
                if (is_mark) begin
                    state_d     = FRAME;
                    field_cnt_d = '0;
                    bit_cnt_d   = '0;
                    frame_ref   = 1'b1;
                end else if (!is_idle) begin
                    state_d = UNLOCKED;
                end
            end
            FRAME: begin
                if (is_illegal) begin
                    err_det = 1'b1;
                end else if (is_data) begin
                    if (bit_cnt_q < BITS_C) bit_cnt_d = bit_cnt_q + BW'(1);
                    else                    err_det   = 1'b1;
                end else if (is_mark) begin
                    if (bit_cnt_q != BITS_C) begin
                        err_det = 1'b1;
                    end else if (field_cnt_q == FIELD_LAST) begin
                        state_d = ENDMARK;
                    end else begin
                        field_cnt_d = field_cnt_q + FW'(1);
                        bit_cnt_d   = '0;
                    end
                end
            end
            ENDMARK: begin
                if (is_mark) begin
                    state_d     = FRAME;
                    field_cnt_d = '0;
                    bit_cnt_d   = '0;
                    frame_ref   = 1'b1;
                    if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + GW'(1);
                end else if (!is_idle) begin
                    err_det = 1'b1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
        // A mark that breaks framing may itself be the next frame reference's first marker.
        if (err_det) begin
            good_cnt_d = '0;
            state_d    = is_mark ? PRELOCK : UNLOCKED;
        end
    end

    always_comb begin
        frame_start_d = frame_ref;
        pps_gate_d    = frame_ref && (state_q == ENDMARK) && (good_cnt_d == GOOD_MAX);
        locked_d      = (good_cnt_d == GOOD_MAX);
        sym_err_d     = err_det;
        bit_strobe_d  = 1'b0;
        field_idx_d   = field_idx_q;
        bit_idx_d     = bit_idx_q;
        bit_value_d   = bit_value_q;
        err_count_d   = err_count_q;
        if (data_ok) begin
            bit_strobe_d = locked_q;
            field_idx_d  = field_cnt_q;
            bit_idx_d    = bit_cnt_q;
            bit_value_d  = irig_d1;
        end
        if (err_det && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
    end

    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign pps_gate    = pps_gate_q;
    assign bit_strobe  = bit_strobe_q;
    assign field_idx   = field_idx_q;
    assign bit_idx     = bit_idx_q;
    assign bit_value   = bit_value_q;
    assign sym_err     = sym_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_irig_frame_sync.sv
// Directed bench for irig_frame_sync: a behavioural model fills a scoreboard per driven symbol,
// and both a 16-bit and a 2-bit error-counter instance are compared against it every cycle.
module tb_irig_frame_sync;

    localparam int FIELDS = 10;
    localparam int BITS   = 9;
    localparam int LF     = 2;

    localparam int S_UNL = 0, S_PRE = 1, S_FRM = 2, S_END = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irig_d0 = 1'b0, irig_d1 = 1'b0, irig_mark = 1'b0;

    logic        locked_a, frame_start_a, pps_gate_a, bit_strobe_a, bit_value_a, sym_err_a;
    logic [3:0]  field_idx_a, bit_idx_a;
    logic [15:0] err_count_a;
    logic        locked_b, frame_start_b, pps_gate_b, bit_strobe_b, bit_value_b, sym_err_b;
    logic [3:0]  field_idx_b, bit_idx_b;
    logic [1:0]  err_count_b;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;

    typedef struct packed {
        logic [29:0] a;
        logic [15:0] b;
    } exp_t;
    exp_t sb_q[$];

    // model state
    int m_state, m_field, m_bit, m_good, m_ec, m_ec2;
    logic m_fs, m_pps, m_bs, m_bv, m_se, m_lk;
    logic [3:0] m_fidx, m_bidx;

    irig_frame_sync #(.FIELDS(FIELDS), .BITS(BITS), .LOCK_FRAMES(LF), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .irig_d0(irig_d0), .irig_d1(irig_d1), .irig_mark(irig_mark),
        .locked(locked_a), .frame_start(frame_start_a), .pps_gate(pps_gate_a),
        .bit_strobe(bit_strobe_a), .field_idx(field_idx_a), .bit_idx(bit_idx_a),
        .bit_value(bit_value_a), .sym_err(sym_err_a), .err_count(err_count_a)
    );

    irig_frame_sync #(.FIELDS(FIELDS), .BITS(BITS), .LOCK_FRAMES(LF), .ERR_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .irig_d0(irig_d0), .irig_d1(irig_d1), .irig_mark(irig_mark),
        .locked(locked_b), .frame_start(frame_start_b), .pps_gate(pps_gate_b),
        .bit_strobe(bit_strobe_b), .field_idx(field_idx_b), .bit_idx(bit_idx_b),
        .bit_value(bit_value_b), .sym_err(sym_err_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = S_UNL; m_field = 0; m_bit = 0; m_good = 0; m_ec = 0; m_ec2 = 0;
        m_fs = 0; m_pps = 0; m_bs = 0; m_bv = 0; m_se = 0; m_lk = 0;
        m_fidx = '0; m_bidx = '0;
    endtask

    task automatic model_step(input logic d0, input logic d1, input logic mk);
        int   n;
        logic idle, illegal, is_mk, is_dat, err, was_locked;
        n = int'(d0) + int'(d1) + int'(mk);
        idle = (n == 0); illegal = (n > 1);
        is_mk = (n == 1) && mk; is_dat = (n == 1) && !mk;
        err = 1'b0;
        was_locked = (m_good == LF);
        m_fs = 0; m_pps = 0; m_bs = 0; m_se = 0;
        case (m_state)
            S_UNL: if (is_mk) m_state = S_PRE;
            S_PRE: begin
                if (is_mk) begin
                    m_state = S_FRM; m_field = 0; m_bit = 0; m_fs = 1;
                end else if (!idle) m_state = S_UNL;
            end
            S_FRM: begin
                if (illegal) err = 1;
                else if (is_dat) begin
                    if (m_bit < BITS) begin
                        m_bs = was_locked; m_fidx = 4'(m_field); m_bidx = 4'(m_bit); m_bv = d1;
                        m_bit++;
                    end else err = 1;
                end else if (is_mk) begin
                    if (m_bit != BITS) err = 1;
                    else if (m_field == FIELDS - 1) m_state = S_END;
                    else begin m_field++; m_bit = 0; end
                end
            end
            default: begin
                if (is_mk) begin
                    m_good = (m_good + 1 > LF) ? LF : m_good + 1;
                    m_state = S_FRM; m_field = 0; m_bit = 0; m_fs = 1;
                    m_pps = (m_good == LF);
                end else if (!idle) err = 1;
            end
        endcase
        if (err) begin
            m_se = 1;
            if (m_ec < 65535) m_ec++;
            if (m_ec2 < 3) m_ec2++;
            m_good = 0;
            m_state = is_mk ? S_PRE : S_UNL;
        end
        m_lk = (m_good == LF);
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.a = {m_fs, m_pps, m_bs, m_fidx, m_bidx, m_bv, m_se, m_lk, 16'(m_ec)};
        e.b = {m_fs, m_pps, m_bs, m_fidx, m_bidx, m_bv, m_se, m_lk, 2'(m_ec2)};
        return e;
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        logic [29:0] obs_a;
        logic [15:0] obs_b;
        e = sb_q.pop_front();
        obs_a = {frame_start_a, pps_gate_a, bit_strobe_a, field_idx_a, bit_idx_a, bit_value_a,
                 sym_err_a, locked_a, err_count_a};
        obs_b = {frame_start_b, pps_gate_b, bit_strobe_b, field_idx_b, bit_idx_b, bit_value_b,
                 sym_err_b, locked_b, err_count_b};
        checks++;
        assert (obs_a === e.a) else begin
            errors++;
            $error("FAIL %s_w16 observed=%h expected=%h", tag, obs_a, e.a);
        end
        checks++;
        assert (obs_b === e.b) else begin
            errors++;
            $error("FAIL %s_w2 observed=%h expected=%h", tag, obs_b, e.b);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step(input logic d0, input logic d1, input logic mk, input string tag);
        @(negedge clk);
        irig_d0 = d0; irig_d1 = d1; irig_mark = mk;
        model_step(d0, d1, mk);
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        irig_d0 = 1'b0; irig_d1 = 1'b0; irig_mark = 1'b0;
        if (bit_strobe_a) n_strobe++;
        compare(tag);
    endtask

    task automatic send_data(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 1'b0, tag);
            else                           step(1'b1, 1'b0, 1'b0, tag);
            if ($urandom_range(0, 5) == 0) step(1'b0, 1'b0, 1'b0, "idle");
        end
    endtask

    task automatic send_fields(input int nf, input string tag);
        for (int f = 0; f < nf; f++) begin
            send_data(BITS, tag);
            step(1'b0, 1'b0, 1'b1, "field_mark");
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(model_exp());
        compare("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: acquisition and first frame, not yet locked
        step(1'b0, 1'b0, 1'b1, "t1_mark1");
        step(1'b0, 1'b0, 1'b1, "t1_mark2");
        check_bit("t1_frame_start_2nd_mark", frame_start_a, 1'b1);
        send_fields(FIELDS, "t1_data");
        step(1'b0, 1'b0, 1'b1, "t1_pr");
        check_bit("t1_frame_start_pr", frame_start_a, 1'b1);
        check_bit("t1_unlocked_after_1frame", locked_a, 1'b0);

        // 2: second frame locks, third frame produces 90 strobes
        send_fields(FIELDS, "t2_data");
        step(1'b0, 1'b0, 1'b1, "t2_pr");
        check_bit("t2_locked", locked_a, 1'b1);
        check_bit("t2_pps", pps_gate_a, 1'b1);
        n_strobe = 0;
        send_fields(FIELDS, "t2_f3");
        checks++;
        assert (n_strobe === 90) else begin
            errors++;
            $error("FAIL t2_strobe_count observed=%0d expected=90", n_strobe);
        end
        step(1'b0, 1'b0, 1'b1, "t2_pr3");
        check_bit("t2_pps_again", pps_gate_a, 1'b1);

        // 3: early marker in field 3
        send_fields(3, "t3_data");
        send_data(5, "t3_bits");
        step(1'b0, 1'b0, 1'b1, "t3_early_mark");
        check_bit("t3_sym_err", sym_err_a, 1'b1);
        check_bit("t3_unlocked", locked_a, 1'b0);
        checks++;
        assert (err_count_a === 16'd1) else begin
            errors++;
            $error("FAIL t3_err_count observed=%0d expected=1", err_count_a);
        end
        step(1'b0, 1'b0, 1'b1, "t3_restart");
        check_bit("t3_frame_start", frame_start_a, 1'b1);

        // 4: relock, then a 10th data symbol in a field
        send_fields(FIELDS, "t4_f1");
        step(1'b0, 1'b0, 1'b1, "t4_pr1");
        send_fields(FIELDS, "t4_f2");
        step(1'b0, 1'b0, 1'b1, "t4_pr2");
        check_bit("t4_locked", locked_a, 1'b1);
        send_data(BITS, "t4_bits");
        step(1'b1, 1'b0, 1'b0, "t4_extra_data");
        check_bit("t4_sym_err", sym_err_a, 1'b1);
        step(1'b1, 1'b0, 1'b0, "t4_d0_unlocked");
        step(1'b0, 1'b0, 1'b1, "t4_mark1");
        step(1'b0, 1'b0, 1'b1, "t4_mark2");
        check_bit("t4_resync", frame_start_a, 1'b1);

        // 5: illegal symbol in FRAME, then in UNLOCKED
        step(1'b1, 1'b0, 1'b1, "t5_illegal_frame");
        check_bit("t5_err_frame", sym_err_a, 1'b1);
        step(1'b1, 1'b0, 1'b1, "t5_illegal_unlocked");
        check_bit("t5_no_err_unlocked", sym_err_a, 1'b0);

        // 6: saturate the narrow counter, then reset mid-frame and relock
        step(1'b0, 1'b0, 1'b1, "t6_mark1");
        step(1'b0, 1'b0, 1'b1, "t6_mark2");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, "t6_err_marks");
        checks++;
        assert (err_count_b === 2'd3) else begin
            errors++;
            $error("FAIL t6_sat observed=%0d expected=3", err_count_b);
        end
        checks++;
        assert (err_count_a === 16'd8) else begin
            errors++;
            $error("FAIL t6_wide_count observed=%0d expected=8", err_count_a);
        end
        send_data(4, "t6_midframe");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb_q.push_back(model_exp());
        compare("t6_async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, "t6_mark1b");
        step(1'b0, 1'b0, 1'b1, "t6_mark2b");
        send_fields(FIELDS, "t6_f1");
        step(1'b0, 1'b0, 1'b1, "t6_pr1");
        check_bit("t6_not_yet", locked_a, 1'b0);
        send_fields(FIELDS, "t6_f2");
        step(1'b0, 1'b0, 1'b1, "t6_pr2");
        check_bit("t6_relocked", locked_a, 1'b1);
        check_bit("t6_relocked_pps", pps_gate_b, 1'b1);

        checks++;
        assert (sb_q.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
